// File: rtl/y86_mem_pkg.sv
// Shared constants and fetch-state encoding for the Y86 instruction memory path.
package y86_mem_pkg;

  localparam int MEM_BYTES    = 1024;
  localparam int WORD_BYTES   = 8;
  localparam int INSTR_BYTES  = 10;
  localparam int WORD_BITS    = WORD_BYTES * 8;
  localparam int WINDOW_WORDS = 3;
  localparam int WINDOW_BITS  = WINDOW_WORDS * WORD_BITS;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    HOLD = 3'd4
  } fetch_state_e;

  // True when a window starting at pc would run past the end of memory.
  function automatic logic window_oob(input logic [63:0] pc,
                                      input int memBytes,
                                      input int instrBytes);
    logic [64:0] endAddr;
    endAddr = {1'b0, pc} + 65'(instrBytes);
    return endAddr > 65'(memBytes);
  endfunction

endpackage

// File: rtl/imem_byte_align.sv
// Extracts the instruction window from up to three captured little-endian words.
module imem_byte_align
  import y86_mem_pkg::*;
#(
  parameter int IN_BYTES  = WINDOW_WORDS * WORD_BYTES,
  parameter int OUT_BYTES = INSTR_BYTES
) (
  input  logic [IN_BYTES*8-1:0]  window_i,
  input  logic [2:0]             offset_i,
  output logic [OUT_BYTES*8-1:0] bytes_o
);

  logic [IN_BYTES*8-1:0] shifted;

  always_comb begin
    shifted = window_i >> {offset_i, 3'b000};
    bytes_o = shifted[OUT_BYTES*8-1:0];
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: reads two or three memory words and presents
// the byte-aligned instruction window to the fetch stage.
module imem_fetch_ctrl #(
  parameter int MEM_BYTES   = y86_mem_pkg::MEM_BYTES,
  parameter int INSTR_BYTES = y86_mem_pkg::INSTR_BYTES
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           f_req,
  input  logic [63:0]                                    f_pc,
  output logic                                           f_busy,
  output logic                                           f_valid,
  input  logic                                           f_ready,
  output logic [INSTR_BYTES*8-1:0]                       f_bytes,
  output logic                                           f_imem_error,
  output logic                                           mem_rd_en,
  output logic [$clog2(MEM_BYTES/y86_mem_pkg::WORD_BYTES)-1:0] mem_addr,
  input  logic [63:0]                                    mem_rdata
);

  import y86_mem_pkg::*;

  localparam int AW = $clog2(MEM_BYTES / WORD_BYTES);

  fetch_state_e           state_q;
  logic [2:0]             off_q;
  logic [AW-1:0]          word_q;
  logic [1:0]             cnt_q;
  logic [WINDOW_BITS-1:0] words_q;
  logic [WINDOW_BITS-1:0] words_d;
  logic                   f_valid_q;
  logic                   f_err_q;
  logic [INSTR_BYTES*8-1:0] f_bytes_q;
  logic [INSTR_BYTES*8-1:0] aligned;
  logic                   rd_en_q;
  logic [AW-1:0]          addr_q;
  logic                   req_oob;
  logic [AW-1:0]          req_word;
  logic                   last_capture;

  assign req_oob      = window_oob(f_pc, MEM_BYTES, INSTR_BYTES);
  assign req_word     = f_pc[AW+2:3];
  assign last_capture = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && (off_q != 3'd7));

  // Slot cnt_q receives the word returning this cycle; the rest is already captured.
  always_comb begin
    words_d = words_q;
    case (cnt_q)
      2'd0:    words_d[WORD_BITS-1:0]             = mem_rdata;
      2'd1:    words_d[2*WORD_BITS-1:WORD_BITS]   = mem_rdata;
      default: words_d[3*WORD_BITS-1:2*WORD_BITS] = mem_rdata;
    endcase
  end

  imem_byte_align #(
    .IN_BYTES  (WINDOW_WORDS * WORD_BYTES),
    .OUT_BYTES (INSTR_BYTES)
  ) u_align (
    .window_i (words_d),
    .offset_i (off_q),
    .bytes_o  (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      off_q     <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      words_q   <= '0;
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      f_bytes_q <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          if (f_req) begin
            off_q   <= f_pc[2:0];
            word_q  <= req_word;
            cnt_q   <= 2'd0;
            words_q <= '0;
            if (req_oob) begin
              f_valid_q <= 1'b1;
              f_err_q   <= 1'b1;
              f_bytes_q <= '0;
              state_q   <= HOLD;
            end else begin
              rd_en_q <= 1'b1;
              addr_q  <= req_word;
              state_q <= RD0;
            end
          end
        end
        RD0: begin
          rd_en_q <= 1'b1;
          addr_q  <= word_q + AW'(1);
          state_q <= RD1;
        end
        RD1: begin
          words_q <= words_d;
          cnt_q   <= 2'd1;
          // Only an offset of 7 spills the window into a third word.
          if (off_q == 3'd7) begin
            rd_en_q <= 1'b1;
            addr_q  <= word_q + AW'(2);
          end else begin
            rd_en_q <= 1'b0;
          end
          state_q <= RD2;
        end
        RD2: begin
          rd_en_q <= 1'b0;
          words_q <= words_d;
          cnt_q   <= cnt_q + 2'd1;
          if (last_capture) begin
            f_bytes_q <= aligned;
            f_valid_q <= 1'b1;
            f_err_q   <= 1'b0;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          rd_en_q <= 1'b0;
          if (f_ready) begin
            f_valid_q <= 1'b0;
            f_err_q   <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          rd_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign f_busy       = (state_q != IDLE);
  assign f_valid      = f_valid_q;
  assign f_imem_error = f_err_q;
  assign f_bytes      = f_bytes_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = addr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected windows and read addresses are
// queued at issue time and compared by independent monitors.
module tb_imem_fetch_ctrl;

  localparam int MEMB = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [63:0] f_pc = '0;
  logic        f_ready = 1'b0;
  logic        f_busy;
  logic        f_valid;
  logic [79:0] f_bytes;
  logic        f_imem_error;
  logic        mem_rd_en;
  logic [6:0]  mem_addr;
  logic [63:0] mem_rdata = '0;

  imem_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .f_req        (f_req),
    .f_pc         (f_pc),
    .f_busy       (f_busy),
    .f_valid      (f_valid),
    .f_ready      (f_ready),
    .f_bytes      (f_bytes),
    .f_imem_error (f_imem_error),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] bytes;
    logic        err;
  } exp_t;

  logic [7:0] tbMem [MEMB];
  exp_t       expQ[$];
  logic [6:0] rdQ[$];
  exp_t       popped;
  logic [6:0] poppedAddr;
  int         checks = 0;
  int         errors = 0;

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] expWindow(input int pc);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[8*k +: 8] = tbMem[pc + k];
    return r;
  endfunction

  // Memory model: data returns the cycle after a sampled read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int b = 0; b < 8; b++) mem_rdata[8*b +: 8] <= tbMem[int'(mem_addr)*8 + b];
    end else begin
      mem_rdata <= 64'hA5A5_5A5A_DEAD_BEEF;
    end
  end

  // Result and read-address monitors.
  always @(negedge clk) begin
    if (f_valid && f_ready) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_result: got f_valid handshake expected none");
      end else begin
        popped = expQ.pop_front();
        checkOutput("f_bytes", f_bytes, popped.bytes);
        checkOutput("f_imem_error", 80'(f_imem_error), 80'(popped.err));
      end
    end
    if (mem_rd_en) begin
      if (rdQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL spurious_read: got read at word %0d expected no read", mem_addr);
      end else begin
        poppedAddr = rdQ.pop_front();
        checkOutput("mem_addr", 80'(mem_addr), 80'(poppedAddr));
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [63:0] pc, input logic err,
                               input int expLat, input int holdCycles, input bit readyEarly);
    logic [79:0] held;
    logic [6:0]  w;
    int          n;
    @(posedge clk); #1;
    if (err) begin
      expQ.push_back('{80'h0, 1'b1});
    end else begin
      expQ.push_back('{expWindow(int'(pc)), 1'b0});
      w = pc[9:3];
      rdQ.push_back(w);
      rdQ.push_back(w + 7'd1);
      if (pc[2:0] == 3'd7) rdQ.push_back(w + 7'd2);
    end
    f_ready = readyEarly;
    f_pc    = pc;
    f_req   = 1'b1;
    @(posedge clk); #1;
    f_req = 1'b0;
    f_pc  = '0;
    n = 0;
    while (!f_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput($sformatf("%s latency", name), 80'(n), 80'(expLat));
    if (!readyEarly) begin
      held = f_bytes;
      for (int i = 0; i < holdCycles; i++) begin
        f_req = i[0];
        f_pc  = 64'(i * 8);
        @(posedge clk); #1;
        checkOutput($sformatf("%s hold valid", name), 80'(f_valid), 80'(1));
        checkOutput($sformatf("%s hold bytes", name), f_bytes, held);
      end
      f_req   = 1'b0;
      f_ready = 1'b1;
    end
    @(posedge clk); #1;
    f_ready = 1'b0;
    checkOutput($sformatf("%s idle busy", name), 80'(f_busy), 80'(0));
    checkOutput($sformatf("%s idle valid", name), 80'(f_valid), 80'(0));
  endtask

  initial begin
    for (int k = 0; k < MEMB; k++) tbMem[k] = 8'((k * 37 + 11) ^ (k >> 3));

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset f_valid", 80'(f_valid), 80'(0));
    checkOutput("reset f_busy", 80'(f_busy), 80'(0));
    checkOutput("reset f_bytes", f_bytes, 80'(0));
    checkOutput("reset f_imem_error", 80'(f_imem_error), 80'(0));
    checkOutput("reset mem_rd_en", 80'(mem_rd_en), 80'(0));
    checkOutput("reset mem_addr", 80'(mem_addr), 80'(0));
    reset = 1'b0;

    applyStimulus("pc0",    64'd0,    1'b0, 3, 0, 1'b1);
    applyStimulus("pc7",    64'd7,    1'b0, 4, 0, 1'b1);
    applyStimulus("pc1014", 64'd1014, 1'b0, 3, 0, 1'b1);
    applyStimulus("pc1015", 64'd1015, 1'b1, 0, 1, 1'b0);
    applyStimulus("pc2p40", 64'd1 << 40, 1'b1, 0, 1, 1'b0);
    applyStimulus("pc3hold", 64'd3,   1'b0, 3, 5, 1'b0);

    // Abort an offset-7 fetch with reset at its third edge.
    @(posedge clk); #1;
    rdQ.push_back(7'd0);
    rdQ.push_back(7'd1);
    f_pc  = 64'd7;
    f_req = 1'b1;
    @(posedge clk); #1;
    f_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort f_valid", 80'(f_valid), 80'(0));
    checkOutput("abort f_busy", 80'(f_busy), 80'(0));
    checkOutput("abort f_bytes", f_bytes, 80'(0));
    checkOutput("abort mem_rd_en", 80'(mem_rd_en), 80'(0));
    checkOutput("abort mem_addr", 80'(mem_addr), 80'(0));
    checkOutput("abort f_imem_error", 80'(f_imem_error), 80'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("abort no valid", 80'(f_valid), 80'(0));
    end

    applyStimulus("pc8", 64'd8, 1'b0, 3, 0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("results drained", 80'(expQ.size()), 80'(0));
    checkOutput("reads drained", 80'(rdQ.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024, meaning instruction memory size in bytes (multiple of 8).
REQ-002 The block SHALL have parameter INSTR_BYTES, default 10, meaning the fetch window width in bytes (maximum Y86 instruction length).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 f_req  in  1  fetch stage requests the window starting at f_pc.
REQ-006 f_pc  in  64  byte address of the instruction.
REQ-007 f_busy  out  1  high when state != IDLE; f_req is ignored while high.
REQ-008 f_valid  out  1  f_bytes and f_imem_error are valid.
REQ-009 f_ready  in  1  fetch stage consumes the result; the handshake completes when f_valid && f_ready.
REQ-010 f_bytes  out  80  bytes PC..PC+9; byte k occupies [8k+7:8k].
REQ-011 f_imem_error  out  1  the window exceeds memory; qualified by f_valid.
REQ-012 mem_rd_en  out  1  word read strobe, registered.
REQ-013 mem_addr  out  7  word index (byte address / 8), registered.
REQ-014 mem_rdata  in  64  little-endian word; byte 0 in [7:0]; valid in the cycle after the edge that samples mem_rd_en=1.

Function
REQ-015 States SHALL be IDLE, RD0, RD1, RD2, HOLD.
REQ-016 In IDLE, f_req=1 at edge E0 SHALL latch f_pc, offset o=f_pc[2:0] and first word w=f_pc[9:3].
REQ-017 If f_pc + INSTR_BYTES > MEM_BYTES (including any f_pc >= 1015 or any of bits 63:10 set), the controller SHALL issue no read, enter HOLD at E0, and present f_valid=1, f_imem_error=1, f_bytes=0.
REQ-018 Otherwise, at E0 the controller SHALL drive mem_rd_en=1, mem_addr=w, and enter RD0.
REQ-019 At E1 in RD0 it SHALL drive mem_addr=w+1 with mem_rd_en=1 and enter RD1.
REQ-020 At E2 in RD1 it SHALL capture word w, and SHALL issue w+2 only when o=7, entering RD2; otherwise it SHALL drop mem_rd_en and enter RD2.
REQ-021 At each later edge it SHALL capture the next returned word.
REQ-022 After the last required word is captured (E3 for o<=6, E4 for o=7), it SHALL enter HOLD with f_valid=1 and f_imem_error=0.
REQ-023 mem_rd_en SHALL be deasserted on every edge at which no new word is issued.
REQ-024 Exactly 2 reads SHALL occur for o<=6 and exactly 3 for o=7; no read SHALL be issued outside these rules.
REQ-025 f_bytes SHALL equal the 24-byte concatenation of the captured words, shifted right by 8*o bytes-in-bits and truncated to 80 bits.
REQ-026 In HOLD, f_valid, f_bytes and f_imem_error SHALL remain stable until f_ready=1.
REQ-027 At the f_ready=1 edge in HOLD, the state SHALL return to IDLE and f_valid SHALL drop; a new request SHALL be accepted no earlier than the following edge.
REQ-028 f_ready in any state other than HOLD SHALL be ignored.
REQ-029 f_req asserted while f_busy=1 SHALL be ignored and not queued.

Reset
REQ-030 While reset=1 at an edge: state=IDLE, f_valid=0, f_imem_error=0, f_bytes=0, mem_rd_en=0, mem_addr=0.
REQ-031 Reset asserted mid-fetch SHALL abort the fetch, and read data returning after reset SHALL be discarded.
REQ-032 Reset SHALL take priority over f_req and f_ready.

Structure
REQ-033 The shared package y86_mem_pkg SHALL hold MEM_BYTES, WORD_BYTES=8, INSTR_BYTES=10 and the fetch-state encoding.
REQ-034 One combinational sub-module, imem_byte_align, SHALL perform the 192-bit-to-80-bit shift by offset o; all sequencing SHALL remain in imem_fetch_ctrl.

Verification
REQ-035 f_pc=0, f_ready=1: reads 0 then 1; f_valid after E3; f_bytes=mem[0..9]; f_imem_error=0.
REQ-036 f_pc=7: reads at words 0, 1, 2; f_valid after E4; f_bytes=mem[7..16].
REQ-037 f_pc=1014: f_bytes=mem[1014..1023], no error; f_pc=1015 and f_pc=2^40: no mem_rd_en, f_valid with f_imem_error=1 after E0.
REQ-038 f_pc=3 with f_ready held low for 5 cycles: f_valid and f_bytes stable; f_req pulses during the hold are ignored; IDLE after the f_ready edge.
REQ-039 Reset at E2 of an f_pc=7 fetch: all outputs zero and no f_valid; the next fetch at f_pc=8 returns mem[8..17].
